// File: rtl/nibble_packer.sv
// Packs per-beat (slice_plus, slice_minus) nibble pairs into OUT_NIBBLES-wide words and queues them in a FIFO.
// Optional macro NIBBLE_PACKER_STALL_CNT_EN adds a saturating stall_count output.
module nibble_packer #(
    parameter int OUT_NIBBLES = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               slice_plus,
    input  logic [3:0]               slice_minus,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*OUT_NIBBLES-1:0] out_data,
    output logic [OUT_NIBBLES-1:0]   out_mask,
    output logic                     out_last
`ifdef NIBBLE_PACKER_STALL_CNT_EN
    ,
    output logic [7:0]               stall_count
`endif
);

    localparam int W     = 4 * OUT_NIBBLES;
    localparam int NIB_W = $clog2(OUT_NIBBLES + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [NIB_W-1:0] NIB_FULL = NIB_W'(OUT_NIBBLES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        EMPTY,
        FILLING
    } state_e;

    typedef struct packed {
        logic [W-1:0]           data;
        logic [OUT_NIBBLES-1:0] mask;
        logic                   last;
    } word_t;

    state_e                 state_q;
    logic [NIB_W-1:0]       nib_cnt_q;
    logic [W-1:0]           acc_q;
    logic [W-1:0]           merged;
    logic [OUT_NIBBLES-1:0] merged_mask;

    word_t                  fifo_q [FIFO_DEPTH];
    word_t                  push_word;
    word_t                  head;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic accept, flush, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Acceptance depends only on registered FIFO occupancy, never on out_ready.
    assign in_ready = (count_q < CNT_FULL);
    assign accept   = in_valid && in_ready;
    assign flush    = accept && ((nib_cnt_q + NIB_W'(2) == NIB_FULL) || in_last);
    assign push     = flush;
    assign pop      = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        merged      = (state_q == EMPTY) ? '0 : acc_q;
        merged_mask = '0;
        for (int k = 0; k < OUT_NIBBLES; k++) begin
            if (NIB_W'(k) == nib_cnt_q) begin
                merged[4*k +: 4] = slice_plus;
            end
            if (NIB_W'(k) == nib_cnt_q + NIB_W'(1)) begin
                merged[4*k +: 4] = slice_minus;
            end
            merged_mask[k] = (NIB_W'(k) < nib_cnt_q + NIB_W'(2));
        end
    end

    assign push_word = '{data: merged, mask: merged_mask, last: in_last};

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            nib_cnt_q <= '0;
            acc_q     <= '0;
        end else if (accept) begin
            if (flush) begin
                state_q   <= EMPTY;
                nib_cnt_q <= '0;
                acc_q     <= '0;
            end else begin
                state_q   <= FILLING;
                nib_cnt_q <= nib_cnt_q + NIB_W'(2);
                acc_q     <= merged;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: the word buffer is reset so the idle head (and thus out_data/out_mask) reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_word;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head      = fifo_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_data  = head.data;
    assign out_mask  = head.mask;
    assign out_last  = head.last;

`ifdef NIBBLE_PACKER_STALL_CNT_EN
    logic [7:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !in_ready && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: directed beats queue hand-computed words, a negedge monitor pops and compares.
module tb_nibble_packer;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  mask;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  slice_plus;
    logic [3:0]  slice_minus;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_mask;
    logic        out_last;
`ifdef NIBBLE_PACKER_STALL_CNT_EN
    logic [7:0]  stall_count;
`endif

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];

    nibble_packer #(.OUT_NIBBLES(4), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .slice_plus (slice_plus),
        .slice_minus(slice_minus),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_mask   (out_mask),
        .out_last   (out_last)
`ifdef NIBBLE_PACKER_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [3:0] m, input logic l);
        exp_q.push_back('{data: d, mask: m, last: l});
    endtask

    // Presents one beat from posedge+1 and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [3:0] p, input logic [3:0] m, input logic l);
        int guard = 0;
        in_valid    = 1'b1;
        slice_plus  = p;
        slice_minus = m;
        in_last     = l;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("in_ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every transferred word and checks the head holds while stalled.
    exp_t mon_prev;
    logic mon_prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t cur;
        cur = '{data: out_data, mask: out_mask, last: out_last};
        if (rst) begin
            mon_prev_stall = 1'b0;
        end else begin
            if (mon_prev_stall && out_valid) begin
                check("hold_stable", 32'(cur), 32'(mon_prev));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(cur), 32'hFFFF_FFFF);
                end else begin
                    check("word", 32'(cur), 32'(exp_q.pop_front()));
                end
            end
            mon_prev_stall = out_valid && !out_ready;
            mon_prev       = cur;
        end
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        slice_plus  = 4'h0;
        slice_minus = 4'h0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  32'(out_data),  32'h0000);
        check("rst_out_mask",  32'(out_mask),  32'h0);
        check("rst_out_last",  32'(out_last),  32'd0);
`ifdef NIBBLE_PACKER_STALL_CNT_EN
        check("rst_stall_count", 32'(stall_count), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Two-beat full word and its one-cycle latency.
        out_ready = 1'b1;
        expect_word(16'hC3A5, 4'hF, 1'b0);
        send_beat(4'h5, 4'hA, 1'b0);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        send_beat(4'h3, 4'hC, 1'b0);
        check("lat_valid", 32'(out_valid), 32'd1);
        wait_drain();

        // Single-beat last frame, then a new frame restarting at slot 0.
        expect_word(16'h00F0, 4'h3, 1'b1);
        send_beat(4'h0, 4'hF, 1'b1);
        expect_word(16'h0021, 4'h3, 1'b1);
        send_beat(4'h1, 4'h2, 1'b1);
        wait_drain();

        // Backpressure: two words fill the FIFO, the fifth beat stalls.
        out_ready = 1'b0;
        expect_word(16'h4321, 4'hF, 1'b0);
        expect_word(16'h8765, 4'hF, 1'b0);
        expect_word(16'hCBA9, 4'hF, 1'b0);
        send_beat(4'h1, 4'h2, 1'b0);
        send_beat(4'h3, 4'h4, 1'b0);
        send_beat(4'h5, 4'h6, 1'b0);
        send_beat(4'h7, 4'h8, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid    = 1'b1;
        slice_plus  = 4'h9;
        slice_minus = 4'hA;
        in_last     = 1'b0;
        idle(3);
        check("stall_in_ready",  32'(in_ready),  32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_head",      32'(out_data),  32'h4321);
`ifdef NIBBLE_PACKER_STALL_CNT_EN
        check("stall_count", 32'(stall_count), 32'd3);
`endif
        out_ready = 1'b1;
        send_beat(4'h9, 4'hA, 1'b0);
        send_beat(4'hB, 4'hC, 1'b0);
        wait_drain();

        // Occupancy 1 with push and pop on the same edge for 10 cycles.
        out_ready = 1'b0;
        expect_word(16'h0011, 4'h3, 1'b1);
        send_beat(4'h1, 4'h1, 1'b1);
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            logic [3:0] p;
            logic [3:0] m;
            p = 4'(i);
            m = 4'(15 - i);
            expect_word({8'h00, m, p}, 4'h3, 1'b1);
            send_beat(p, m, 1'b1);
            check("pp_out_valid", 32'(out_valid), 32'd1);
            check("pp_in_ready",  32'(in_ready),  32'd1);
        end
        wait_drain();

        // Reset mid-frame discards the partial word.
        send_beat(4'h7, 4'h7, 1'b0);
        rst = 1'b1;
        idle(2);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_word(16'h4321, 4'hF, 1'b0);
        send_beat(4'h1, 4'h2, 1'b0);
        send_beat(4'h3, 4'h4, 1'b0);
        wait_drain();

        idle(5);
        check("final_out_valid", 32'(out_valid), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
